// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the sequential approximate multiplier.
// Build option: define APPROX_MUL_ZERO_SKIP_EN to short-circuit zero operands.
package approx_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned NSTEPS    = 4;
    localparam logic [1:0]  LAST_STEP = 2'(NSTEPS - 1);

    localparam logic [5:0] SHIFT_STEP0 = 6'd0;
    localparam logic [5:0] SHIFT_STEP1 = 6'd16;
    localparam logic [5:0] SHIFT_STEP2 = 6'd16;
    localparam logic [5:0] SHIFT_STEP3 = 6'd32;

    function automatic logic [5:0] step_shift(input logic [1:0] step);
        logic [5:0] sh;
        case (step)
            2'd0:    sh = SHIFT_STEP0;
            2'd1:    sh = SHIFT_STEP1;
            2'd2:    sh = SHIFT_STEP2;
            default: sh = SHIFT_STEP3;
        endcase
        return sh;
    endfunction

    // Low n bits are OR-ed (no carry leaves them); the rest is an exact add.
    function automatic logic [31:0] approx_add32(input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input int unsigned n);
        logic [31:0] mask;
        mask = (n >= 32) ? '1 : ((32'h1 << n) - 32'h1);
        return ((a & ~mask) + (b & ~mask)) | ((a | b) & mask);
    endfunction

endpackage

// File: rtl/approx_acc_add.sv
// 64-bit accumulator adder: the low N32 bits are OR-approximated, the upper
// bits are an exact add with carry-in 0. Carry out of bit 63 is dropped.
module approx_acc_add #(
    parameter int N32 = 0
) (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum
);

    if (N32 <= 0) begin : g_exact
        assign sum = a + b;
    end else if (N32 >= 64) begin : g_all_or
        assign sum = a | b;
    end else begin : g_split
        logic [63-N32:0] hi;
        assign hi  = a[63:N32] + b[63:N32];
        assign sum = {hi, a[N32-1:0] | b[N32-1:0]};
    end

endmodule

// File: rtl/x16_approx_mul.sv
// 16x16 approximate multiplier built from 8x8 blocks (themselves from 4x4
// products); N4/N8/N16 select how many low bits each combining adder ORs.
module x16_approx_mul
    import approx_mul_pkg::*;
#(
    parameter int N16 = 0,
    parameter int N8  = 0,
    parameter int N4  = 0
) (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    // pp8 index: 0 = aL*bL, 1 = aL*bH, 2 = aH*bL, 3 = aH*bH
    logic [15:0] pp8 [4];
    logic [31:0] mid16;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_pp8
        logic [7:0]  a8, b8;
        logic [7:0]  p_ll, p_lh, p_hl, p_hh;
        logic [15:0] mid8;

        assign a8 = a[8*(gi/2) +: 8];
        assign b8 = b[8*(gi%2) +: 8];

        assign p_ll = {4'b0, a8[3:0]} * {4'b0, b8[3:0]};
        assign p_lh = {4'b0, a8[3:0]} * {4'b0, b8[7:4]};
        assign p_hl = {4'b0, a8[7:4]} * {4'b0, b8[3:0]};
        assign p_hh = {4'b0, a8[7:4]} * {4'b0, b8[7:4]};

        assign mid8    = 16'(approx_add32(32'(p_lh) << 4, 32'(p_hl) << 4, N4));
        assign pp8[gi] = 16'(approx_add32(32'({p_hh, p_ll}), 32'(mid8), N4));
    end

    assign mid16 = approx_add32(32'(pp8[1]) << 8, 32'(pp8[2]) << 8, N8);
    assign p     = approx_add32({pp8[3], pp8[0]}, mid16, N16);

endmodule

// File: rtl/approx_mul_seq32.sv
// Sequential 32x32 approximate multiplier: one 16x16 core reused over four
// steps, sign-magnitude handling, valid/ready on both sides.
// Build option: APPROX_MUL_ZERO_SKIP_EN sends zero operands straight to DONE.
module approx_mul_seq32
    import approx_mul_pkg::*;
#(
    parameter int N32 = 0,
    parameter int N16 = 0,
    parameter int N8  = 0,
    parameter int N4  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_a_signed,
    input  logic        in_b_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic        busy
);

    state_t      state_reg, state_next;
    logic [31:0] a_mag_reg, b_mag_reg;
    logic        neg_reg;
    logic [63:0] acc_reg;
    logic [63:0] result_reg;
    logic [1:0]  step_reg;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        accept;
    logic        zero_op;
    logic [15:0] core_a, core_b;
    logic [31:0] core_p;
    logic [63:0] pp_shifted;
    logic [63:0] acc_sum;

    // Two's-complement negate of 0x80000000 yields 0x80000000, the correct magnitude.
    assign a_neg  = in_a_signed & in_a[31];
    assign b_neg  = in_b_signed & in_b[31];
    assign a_mag  = a_neg ? (~in_a + 32'd1) : in_a;
    assign b_mag  = b_neg ? (~in_b + 32'd1) : in_b;
    assign accept = in_valid & in_ready;

`ifdef APPROX_MUL_ZERO_SKIP_EN
    assign zero_op = (a_mag == 32'd0) || (b_mag == 32'd0);
`else
    assign zero_op = 1'b0;
`endif

    // step[1] picks the a half, step[0] the b half.
    assign core_a     = step_reg[1] ? a_mag_reg[31:16] : a_mag_reg[15:0];
    assign core_b     = step_reg[0] ? b_mag_reg[31:16] : b_mag_reg[15:0];
    assign pp_shifted = 64'(core_p) << step_shift(step_reg);

    x16_approx_mul #(
        .N16 (N16),
        .N8  (N8),
        .N4  (N4)
    ) u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    approx_acc_add #(
        .N32 (N32)
    ) u_acc_add (
        .a   (acc_reg),
        .b   (pp_shifted),
        .sum (acc_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = zero_op ? DONE : MUL;
            MUL:  if (step_reg == LAST_STEP) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
        busy      = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_mag_reg  <= '0;
            b_mag_reg  <= '0;
            neg_reg    <= 1'b0;
            acc_reg    <= '0;
            result_reg <= '0;
            step_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_mag_reg <= a_mag;
                        b_mag_reg <= b_mag;
                        neg_reg   <= a_neg ^ b_neg;
                        acc_reg   <= '0;
                        step_reg  <= '0;
                        if (zero_op) begin
                            result_reg <= '0;
                        end
                    end
                end
                MUL: begin
                    acc_reg  <= acc_sum;
                    step_reg <= step_reg + 2'd1;
                end
                FIX: begin
                    result_reg <= neg_reg ? (~acc_reg + 64'd1) : acc_reg;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_result = result_reg;

endmodule
